// File: rtl/fourier_seq_ctrl.sv
// fourier_seq_ctrl: frame sequencer for the fourier_srg RNS Fourier datapath.
// Optional BUSY watchdog and ERR state: define FOURIER_SEQ_TIMEOUT_EN.
module fourier_seq_ctrl #(
   parameter int N = 10,
   parameter int W = 32
`ifdef FOURIER_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 1024
`endif
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_re,
   output logic [W-1:0] out_im,
   output logic         out_last,
   output logic         busy,
   output logic         frame_done,
   output logic         error,
   output logic [31:0]  dp_addr,
   output logic [W-1:0] dp_x,
   output logic [1:0]   dp_operation,
   input  logic [W-1:0] dp_y_re,
   input  logic [W-1:0] dp_y_im,
   input  logic         dp_done
);

   localparam int KW = $clog2(N);
   localparam logic [KW-1:0] KMAX = KW'(N - 1);

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_COMP = 2'b10;
   localparam logic [1:0] OP_READ = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_BUSY,
      S_RDCMD,
      S_RDCAP,
      S_OUT,
      S_ERR
   } state_t;

   state_t        state_q;
   logic [KW-1:0] k_q;
   logic          out_valid_q;
   logic [W-1:0]  out_re_q;
   logic [W-1:0]  out_im_q;
   logic          out_last_q;
   logic          busy_q;
   logic          frame_done_q;
   logic [31:0]   dp_addr_q;
   logic [W-1:0]  dp_x_q;
   logic [1:0]    dp_op_q;

`ifdef FOURIER_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CTOP  = CW'(TIMEOUT);

   logic [CW-1:0] cnt_q;
   logic          error_q;
   logic          tmo;

   assign tmo   = (cnt_q == CLAST);
   assign error = error_q;

   // watchdog: held at zero outside BUSY, counts BUSY cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (state_q != S_BUSY) begin
         cnt_q <= '0;
      end else if (cnt_q != CTOP) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
`else
   assign error = 1'b0;
`endif

   assign in_ready     = (state_q == S_LOAD);
   assign out_valid    = out_valid_q;
   assign out_re       = out_re_q;
   assign out_im       = out_im_q;
   assign out_last     = out_last_q;
   assign busy         = busy_q;
   assign frame_done   = frame_done_q;
   assign dp_addr      = dp_addr_q;
   assign dp_x         = dp_x_q;
   assign dp_operation = dp_op_q;

   // frame FSM with registered datapath commands and output stream
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         k_q          <= '0;
         out_valid_q  <= 1'b0;
         out_re_q     <= '0;
         out_im_q     <= '0;
         out_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         dp_addr_q    <= '0;
         dp_x_q       <= '0;
         dp_op_q      <= OP_NOP;
`ifdef FOURIER_SEQ_TIMEOUT_EN
         error_q      <= 1'b0;
`endif
      end else begin
         frame_done_q <= 1'b0;
         unique case (state_q)
            S_IDLE, S_ERR: begin
               if (start) begin
                  state_q <= S_LOAD;
                  k_q     <= '0;
                  busy_q  <= 1'b1;
`ifdef FOURIER_SEQ_TIMEOUT_EN
                  error_q <= 1'b0;
`endif
               end
            end
            S_LOAD: begin
               dp_op_q <= OP_NOP;
               if (in_valid) begin
                  dp_addr_q <= 32'(k_q);
                  dp_x_q    <= in_data;
                  dp_op_q   <= OP_LOAD;
                  if (k_q == KMAX) begin
                     state_q <= S_START;
                  end else begin
                     k_q <= k_q + 1'b1;
                  end
               end
            end
            S_START: begin
               dp_op_q <= OP_COMP;
               state_q <= S_BUSY;
            end
            S_BUSY: begin
               dp_op_q <= OP_NOP;
               if (dp_done) begin
                  state_q   <= S_RDCMD;
                  k_q       <= '0;
                  dp_addr_q <= '0;
                  dp_op_q   <= OP_READ;
               end
`ifdef FOURIER_SEQ_TIMEOUT_EN
               else if (tmo) begin
                  state_q <= S_ERR;
                  busy_q  <= 1'b0;
                  error_q <= 1'b1;
               end
`endif
            end
            S_RDCMD: begin
               dp_op_q <= OP_NOP;
               state_q <= S_RDCAP;
            end
            S_RDCAP: begin
               out_re_q    <= dp_y_re;
               out_im_q    <= dp_y_im;
               out_last_q  <= (k_q == KMAX);
               out_valid_q <= 1'b1;
               state_q     <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (k_q == KMAX) begin
                     state_q      <= S_IDLE;
                     busy_q       <= 1'b0;
                     frame_done_q <= 1'b1;
                  end else begin
                     k_q       <= k_q + 1'b1;
                     dp_addr_q <= 32'(k_q) + 32'd1;
                     dp_op_q   <= OP_READ;
                     state_q   <= S_RDCMD;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
